// File: rtl/ram_arbiter_pkg.sv
// Shared constants for genram clients: command encoding, port-id type, default widths.
package ram_arbiter_pkg;
   localparam int unsigned RAM_AW  = 8;
   localparam int unsigned RAM_DW  = 11;
   localparam int unsigned N_PORTS = 2;
   localparam int unsigned PORT_W  = 1;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef logic [PORT_W-1:0] port_id_t;
endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; on a tie the port not granted most recently wins.
module rr_arbiter2
   import ram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output port_id_t   grant_id
);

   logic last;

   always_comb begin
      grant = '0;
      if (!rst) begin
         grant[0] = req[0] & (~req[1] | last);
         grant[1] = req[1] & (~req[0] | ~last);
      end
   end

   assign grant_id = port_id_t'(grant[1]);

   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (|grant)
         last <= grant[1];
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin sequencer in front of a single-port genram; fixed 2-cycle latency.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned AW = RAM_AW,
   parameter int unsigned DW = RAM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [1:0]    req_rw,
   input  logic [AW-1:0] req_addr  [N_PORTS],
   input  logic [DW-1:0] req_wdata [N_PORTS],
   output logic [1:0]    rsp_valid,
   output logic [DW-1:0] rsp_data  [N_PORTS],
   output logic          ram_cs,
   output logic          ram_rw,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   port_id_t grant_id;
   port_id_t s1_port;
   logic     s2_valid;
   port_id_t s2_port;
   logic     s2_rw;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_valid),
      .grant    (req_ready),
      .grant_id (grant_id)
   );

   // Stage 1: granted command onto the RAM pins; pins hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_cs   <= 1'b0;
         ram_rw   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         s1_port  <= '0;
      end else begin
         ram_cs <= |req_ready;
         if (|req_ready) begin
            ram_rw   <= req_rw[grant_id];
            ram_addr <= req_addr[grant_id];
            ram_din  <= req_wdata[grant_id];
            s1_port  <= grant_id;
         end
      end
   end

   // Stage 2: routing info aligned with genram's output; reset drops in-flight commands.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_port  <= '0;
         s2_rw    <= 1'b0;
      end else begin
         s2_valid <= ram_cs;
         s2_port  <= s1_port;
         s2_rw    <= ram_rw;
      end
   end

   always_comb begin
      rsp_valid   = '0;
      rsp_data[0] = '0;
      rsp_data[1] = '0;
      rsp_valid[s2_port] = s2_valid;
      if (s2_valid) begin
         case (s2_rw)
            RW_READ:  rsp_data[s2_port] = ram_dout;
            RW_WRITE: rsp_data[s2_port] = '0;
            default:  rsp_data[s2_port] = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table plus reset/random sequences for ram_arbiter against a behavioural genram.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_rw;
   logic [7:0]  req_addr  [2];
   logic [10:0] req_wdata [2];
   logic [1:0]  rsp_valid;
   logic [10:0] rsp_data  [2];
   logic        ram_cs;
   logic        ram_rw;
   logic [7:0]  ram_addr;
   logic [10:0] ram_din;
   logic [10:0] ram_dout;

   logic [10:0] mem [256];
   logic [10:0] sb  [256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ram_cs    (ram_cs),
      .ram_rw    (ram_rw),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // genram: synchronous single-port RAM, rw=1 read
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_rw) ram_dout <= mem[ram_addr];
         else        mem[ram_addr] <= ram_din;
      end
   end

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  rw;
      logic [7:0]  a0, a1;
      logic [10:0] w0, w1;
      logic [1:0]  e_ready;
      logic        e_cs, e_rw;
      logic [7:0]  e_addr;
      logic [1:0]  e_rv;
      logic [10:0] e_d0, e_d1;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] rw, input logic [7:0] a0,
                        input logic [7:0] a1, input logic [10:0] w0, input logic [10:0] w1);
      req_valid    = v;
      req_rw       = rw;
      req_addr[0]  = a0;
      req_addr[1]  = a1;
      req_wdata[0] = w0;
      req_wdata[1] = w1;
   endtask

   // Advance to 1ns after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string nm, input logic [1:0] rv, input logic [10:0] d0,
                          input logic [10:0] d1);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(rv));
      chk({nm, " rsp_data0"}, 32'(rsp_data[0]), 32'(d0));
      chk({nm, " rsp_data1"}, 32'(rsp_data[1]), 32'(d1));
   endtask

   initial begin
      logic        m_last;
      logic [1:0]  e_ready;
      logic [1:0]  v, rw;
      logic [7:0]  a0, a1;
      logic [10:0] w0, w1;
      logic        p1_v, p2_v, c_v;
      logic        p1_p, p2_p, c_p;
      logic [10:0] p1_d, p2_d, c_d;
      logic [1:0]  e_rv;
      logic [10:0] e_d [2];

      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[1] = 11'h111;
      mem[2] = 11'h222;
      ram_dout = '0;

      //   v     rw    a0     a1     w0      w1      rdy   cs    rw    addr   rv    d0      d1
      tbl[0]  = '{2'b01,2'b00,8'h10,8'h00,11'h2A5,11'h000,2'b01,1'b0,1'b0,8'h00,2'b00,11'h000,11'h000};
      tbl[1]  = '{2'b01,2'b01,8'h10,8'h00,11'h000,11'h000,2'b01,1'b1,1'b0,8'h10,2'b00,11'h000,11'h000};
      tbl[2]  = '{2'b00,2'b00,8'h00,8'h00,11'h000,11'h000,2'b00,1'b1,1'b1,8'h10,2'b01,11'h000,11'h000};
      tbl[3]  = '{2'b11,2'b11,8'h01,8'h02,11'h000,11'h000,2'b10,1'b0,1'b1,8'h10,2'b01,11'h2A5,11'h000};
      tbl[4]  = '{2'b11,2'b11,8'h01,8'h02,11'h000,11'h000,2'b01,1'b1,1'b1,8'h02,2'b00,11'h000,11'h000};
      tbl[5]  = '{2'b11,2'b11,8'h01,8'h02,11'h000,11'h000,2'b10,1'b1,1'b1,8'h01,2'b10,11'h000,11'h222};
      tbl[6]  = '{2'b11,2'b11,8'h01,8'h02,11'h000,11'h000,2'b01,1'b1,1'b1,8'h02,2'b01,11'h111,11'h000};
      tbl[7]  = '{2'b00,2'b00,8'h00,8'h00,11'h000,11'h000,2'b00,1'b1,1'b1,8'h01,2'b10,11'h000,11'h222};
      tbl[8]  = '{2'b10,2'b00,8'h00,8'h20,11'h000,11'h155,2'b10,1'b0,1'b1,8'h01,2'b01,11'h111,11'h000};
      tbl[9]  = '{2'b10,2'b10,8'h00,8'h20,11'h000,11'h000,2'b10,1'b1,1'b0,8'h20,2'b00,11'h000,11'h000};
      tbl[10] = '{2'b10,2'b10,8'h00,8'h02,11'h000,11'h000,2'b10,1'b1,1'b1,8'h20,2'b10,11'h000,11'h000};
      tbl[11] = '{2'b11,2'b11,8'h01,8'h20,11'h000,11'h000,2'b01,1'b1,1'b1,8'h02,2'b10,11'h000,11'h155};
      tbl[12] = '{2'b11,2'b11,8'h01,8'h20,11'h000,11'h000,2'b10,1'b1,1'b1,8'h01,2'b10,11'h000,11'h222};
      tbl[13] = '{2'b00,2'b00,8'h00,8'h00,11'h000,11'h000,2'b00,1'b1,1'b1,8'h20,2'b01,11'h111,11'h000};
      tbl[14] = '{2'b00,2'b00,8'h00,8'h00,11'h000,11'h000,2'b00,1'b0,1'b1,8'h20,2'b10,11'h000,11'h155};
      tbl[15] = '{2'b00,2'b00,8'h00,8'h00,11'h000,11'h000,2'b00,1'b0,1'b1,8'h20,2'b00,11'h000,11'h000};

      // Reset with both ports requesting: nothing accepted, outputs cleared.
      rst = 1'b1;
      drive(2'b11, 2'b00, 8'h33, 8'h44, 11'h7FF, 11'h7FF);
      repeat (3) next_cycle();
      #4;
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset ram_cs", 32'(ram_cs), 32'd0);
      chk("reset ram_rw", 32'(ram_rw), 32'd0);
      chk("reset ram_addr", 32'(ram_addr), 32'd0);
      chk("reset ram_din", 32'(ram_din), 32'd0);
      chk_rsp("reset", 2'b00, 11'h0, 11'h0);
      next_cycle();
      rst = 1'b0;
      drive(2'b00, 2'b00, 8'h0, 8'h0, 11'h0, 11'h0);

      for (int i = 0; i < 16; i++) begin
         string nm;
         next_cycle();
         drive(tbl[i].v, tbl[i].rw, tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1);
         #4;
         nm = $sformatf("row%0d", i);
         chk({nm, " req_ready"}, 32'(req_ready), 32'(tbl[i].e_ready));
         chk({nm, " ram_cs"}, 32'(ram_cs), 32'(tbl[i].e_cs));
         chk({nm, " ram_rw"}, 32'(ram_rw), 32'(tbl[i].e_rw));
         chk({nm, " ram_addr"}, 32'(ram_addr), 32'(tbl[i].e_addr));
         chk_rsp(nm, tbl[i].e_rv, tbl[i].e_d0, tbl[i].e_d1);
      end

      // Reset one cycle after a read is accepted: the read must never respond.
      next_cycle();
      drive(2'b01, 2'b01, 8'h01, 8'h02, 11'h0, 11'h0);
      #4 chk("rstseq accept", 32'(req_ready), 32'd1);
      next_cycle();
      rst = 1'b1;
      drive(2'b11, 2'b11, 8'h02, 8'h01, 11'h0, 11'h0);
      #4 chk("rstseq ready0", 32'(req_ready), 32'd0);
      chk("rstseq cs", 32'(ram_cs), 32'd1);
      next_cycle();
      #4 chk("rstseq ready1", 32'(req_ready), 32'd0);
      chk("rstseq cs cleared", 32'(ram_cs), 32'd0);
      chk_rsp("rstseq dropped", 2'b00, 11'h0, 11'h0);
      next_cycle();
      rst = 1'b0;
      drive(2'b00, 2'b00, 8'h0, 8'h0, 11'h0, 11'h0);
      #4 chk_rsp("rstseq post", 2'b00, 11'h0, 11'h0);
      next_cycle();
      drive(2'b11, 2'b11, 8'h02, 8'h01, 11'h0, 11'h0);
      #4 chk("rstseq first tie", 32'(req_ready), 32'd1);
      next_cycle();
      drive(2'b00, 2'b00, 8'h0, 8'h0, 11'h0, 11'h0);
      #4 chk_rsp("rstseq idle", 2'b00, 11'h0, 11'h0);
      next_cycle();
      #4 chk_rsp("rstseq tie rsp", 2'b01, 11'h222, 11'h0);
      next_cycle();
      #4 chk_rsp("rstseq drained", 2'b00, 11'h0, 11'h0);

      // Random mixed traffic against a scoreboard memory.
      for (int i = 0; i < 256; i++) sb[i] = mem[i];
      m_last = 1'b0;
      p1_v = 1'b0; p1_p = 1'b0; p1_d = '0;
      p2_v = 1'b0; p2_p = 1'b0; p2_d = '0;
      for (int t = 0; t < 304; t++) begin
         next_cycle();
         if (t < 300) begin
            v  = 2'($urandom_range(0, 3));
            rw = 2'($urandom_range(0, 3));
         end else begin
            v  = 2'b00;
            rw = 2'b00;
         end
         a0 = 8'($urandom_range(0, 7));
         a1 = 8'($urandom_range(0, 7));
         w0 = 11'($urandom);
         w1 = 11'($urandom);
         drive(v, rw, a0, a1, w0, w1);
         #4;
         p2_v = p1_v; p2_p = p1_p; p2_d = p1_d;
         p1_v = c_v;  p1_p = c_p;  p1_d = c_d;
         if (t == 0) begin
            p1_v = 1'b0;
            p2_v = 1'b0;
         end
         e_rv   = 2'b00;
         e_d[0] = '0;
         e_d[1] = '0;
         if (p2_v) begin
            e_rv[p2_p] = 1'b1;
            e_d[p2_p]  = p2_d;
         end
         chk_rsp($sformatf("rand%0d", t), e_rv, e_d[0], e_d[1]);
         e_ready = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
         chk($sformatf("rand%0d req_ready", t), 32'(req_ready), 32'(e_ready));
         c_v = |e_ready;
         c_p = e_ready[1];
         c_d = '0;
         if (c_v) begin
            m_last = c_p;
            if (rw[c_p]) c_d = sb[c_p ? a1 : a0];
            else sb[c_p ? a1 : a0] = c_p ? w1 : w0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
